tiny_soc_mem_arbiter: RTL and testbench

- Multi-port memory front-end for the tiny SoC test harness; sits between N core-side memory requestors (instruction/data/DMA ports of the core wrapper) and a single-port SRAM macro.
- Arbitrates requests round-robin and relocates byte addresses to SRAM word indices.
- Expands byte strobes to a bit mask and returns read data after a fixed, parametrised latency.
- Also decodes an end-of-benchmark MMIO write and latches its code.

---
 rtl/tiny_soc_mem_pkg.sv | 27 ++
 rtl/tiny_soc_rr_arbiter.sv | 44 ++++
 rtl/tiny_soc_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_tiny_soc_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny_soc_mem_pkg.sv
// Shared types for the tiny SoC memory front-end: response metadata carried
// through the read-latency pipe, and byte-strobe to bit-mask expansion.
package tiny_soc_mem_pkg;

  localparam int MaxPorts = 8;
  localparam int PortIdxW = $clog2(MaxPorts);

  typedef logic [31:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  typedef struct packed {
    logic [PortIdxW-1:0] port_idx;
    logic                err;
    logic                is_read;
  } resp_meta_t;

  function automatic data_t strb_to_mask(input strb_t strb);
    data_t m;
    m = '0;
    for (int unsigned i = 0; i < $bits(strb_t); i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tiny_soc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// pointer with wrap-around; pointer moves past the winner after each grant.
module tiny_soc_rr_arbiter #(
  parameter int NumPorts = 2,
  localparam int PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NumPorts-1:0] i_req,
  output logic [NumPorts-1:0] o_gnt,
  output logic                o_valid,
  output logic [PtrW-1:0]     o_idx
);

  logic [PtrW-1:0] r_ptr;

  always_comb begin
    int unsigned p;
    p       = 0;
    o_gnt   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    // Grants are suppressed while reset is held so nothing reaches the SRAM.
    if (i_rst_n) begin
      for (int unsigned off = 0; off < NumPorts; off++) begin
        p = (32'(r_ptr) + off) % NumPorts;
        if (!o_valid && i_req[p]) begin
          o_gnt[p] = 1'b1;
          o_valid  = 1'b1;
          o_idx    = PtrW'(p);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (32'(o_idx) == NumPorts - 1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tiny_soc_mem_arbiter.sv
// Multi-port SRAM front-end: round-robin arbitration, address relocation,
// fixed-latency responses and end-of-benchmark capture. TINY_SOC_MEM_STATS_EN adds counters.
module tiny_soc_mem_arbiter
  import tiny_soc_mem_pkg::*;
#(
  parameter int                   NumPorts   = 2,
  parameter int                   AddrWidth  = 32,
  parameter int                   DataWidth  = 64,
  parameter int                   NumWords   = 1 << 17,
  parameter logic [AddrWidth-1:0] RelocBase  = 32'h8000_0000,
  parameter int                   MemLatency = 1,
  parameter logic [AddrWidth-1:0] EobAddr    = 32'h0000_0000,
  localparam int                  StrbWidth  = DataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             gnt_o,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts*StrbWidth-1:0]   be_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            err_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [$clog2(NumWords)-1:0]     mem_addr_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth-1:0]            mem_wmask_o,
  input  logic [DataWidth-1:0]            mem_rdata_i,
  output logic                            eob_valid_o,
  output logic [31:0]                     eob_code_o
`ifdef TINY_SOC_MEM_STATS_EN
  ,
  output logic [NumPorts*32-1:0]          stat_grants_o,
  output logic [31:0]                     stat_errs_o
`endif
);

  localparam int OffW = $clog2(StrbWidth);
  localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic                 w_valid;
  logic [PtrW-1:0]      w_idx;
  logic                 w_we;
  logic [AddrWidth-1:0] w_addr;
  logic [StrbWidth-1:0] w_be;
  logic [DataWidth-1:0] w_wdata;
  logic [AddrWidth-1:0] w_word;
  logic                 w_in_range;
  logic                 w_is_eob;
  logic                 w_sram;
  logic                 w_err;
  resp_meta_t           w_meta;
  resp_meta_t           w_out;
  logic                 w_out_vld;

  logic                 r_vld  [MemLatency];
  resp_meta_t           r_meta [MemLatency];
  logic                 r_eob_valid;
  logic [31:0]          r_eob_code;

  tiny_soc_rr_arbiter #(.NumPorts(NumPorts)) u_arb (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_req   (req_i),
    .o_gnt   (gnt_o),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_be    = '0;
    w_wdata = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (gnt_o[p]) begin
        w_we    = we_i[p];
        w_addr  = addr_i[p*AddrWidth +: AddrWidth];
        w_be    = be_i[p*StrbWidth +: StrbWidth];
        w_wdata = wdata_i[p*DataWidth +: DataWidth];
      end
    end
  end

  // Subtraction wraps, so addresses below RelocBase land far out of range.
  assign w_word     = (w_addr - RelocBase) >> OffW;
  assign w_in_range = (w_word < AddrWidth'(NumWords));
  assign w_is_eob   = w_valid && w_we && (w_addr == EobAddr);
  assign w_sram     = w_valid && !w_is_eob && w_in_range;
  assign w_err      = w_valid && !w_is_eob && !w_in_range;

  assign mem_req_o   = w_sram;
  assign mem_we_o    = w_sram && w_we;
  assign mem_addr_o  = w_word[$clog2(NumWords)-1:0];
  assign mem_wdata_o = w_wdata;

  if (DataWidth == $bits(data_t)) begin : g_mask_pkg
    assign mem_wmask_o = strb_to_mask(w_be);
  end else begin : g_mask_loop
    always_comb begin
      mem_wmask_o = '0;
      for (int unsigned i = 0; i < StrbWidth; i++) begin
        mem_wmask_o[8*i +: 8] = {8{w_be[i]}};
      end
    end
  end

  always_comb begin
    w_meta          = '0;
    w_meta.port_idx = PortIdxW'(w_idx);
    w_meta.err      = w_err;
    w_meta.is_read  = !w_we;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MemLatency; i++) begin
        r_vld[i]  <= 1'b0;
        r_meta[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_valid;
      r_meta[0] <= w_meta;
      for (int unsigned i = 1; i < MemLatency; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_meta[i] <= r_meta[i-1];
      end
    end
  end

  assign w_out_vld = r_vld[MemLatency-1];
  assign w_out     = r_meta[MemLatency-1];

  always_comb begin
    rvalid_o = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = w_out_vld && (w_out.port_idx == PortIdxW'(p));
    end
  end

  assign err_o   = w_out_vld && w_out.err;
  assign rdata_o = (w_out_vld && w_out.is_read && !w_out.err) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_eob_valid <= 1'b0;
      r_eob_code  <= '0;
    end else if (w_is_eob && !r_eob_valid) begin
      r_eob_valid <= 1'b1;
      r_eob_code  <= w_wdata[31:0];
    end
  end

  assign eob_valid_o = r_eob_valid;
  assign eob_code_o  = r_eob_code;

`ifdef TINY_SOC_MEM_STATS_EN
  logic [31:0] r_grant_cnt [NumPorts];
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NumPorts; p++) r_grant_cnt[p] <= '0;
      r_err_cnt <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (gnt_o[p] && (r_grant_cnt[p] != '1)) r_grant_cnt[p] <= r_grant_cnt[p] + 1'b1;
      end
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_comb begin
    stat_grants_o = '0;
    for (int unsigned p = 0; p < NumPorts; p++) stat_grants_o[p*32 +: 32] = r_grant_cnt[p];
  end
  assign stat_errs_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_tiny_soc_mem_arbiter.sv
// Directed bench: single-port latency-1 instance driven from a vector table,
// three-port latency-3 instance exercised by hand-written sequences.
module tb_tiny_soc_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- single-port instance ----------------
  logic [0:0]  req1, gnt1, we1, rvalid1;
  logic [31:0] addr1;
  logic [7:0]  be1;
  logic [63:0] wdata1, rdata1, m1_wdata, m1_mask;
  logic [63:0] m1_rdata = '0;
  logic        err1, m1_req, m1_we, eobv1;
  logic [16:0] m1_addr;
  logic [31:0] eobc1;

  tiny_soc_mem_arbiter #(.NumPorts(1), .MemLatency(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .gnt_o(gnt1), .we_i(we1),
    .addr_i(addr1), .be_i(be1), .wdata_i(wdata1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .err_o(err1), .mem_req_o(m1_req), .mem_we_o(m1_we),
    .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata), .mem_wmask_o(m1_mask),
    .mem_rdata_i(m1_rdata), .eob_valid_o(eobv1), .eob_code_o(eobc1)
  );

  logic [63:0] mem1 [int unsigned];
  logic [63:0] old1;
  always @(posedge clk) begin
    if (m1_req) begin
      old1 = mem1.exists(32'(m1_addr)) ? mem1[32'(m1_addr)] : 64'd0;
      if (m1_we) mem1[32'(m1_addr)] = (old1 & ~m1_mask) | (m1_wdata & m1_mask);
      else       m1_rdata <= old1;
    end
  end

  // ---------------- three-port instance ----------------
  logic [2:0]   req3, gnt3, we3, rvalid3;
  logic [95:0]  addr3;
  logic [23:0]  be3;
  logic [191:0] wdata3;
  logic [63:0]  rdata3, m3_wdata, m3_mask, m3_rdata;
  logic         err3, m3_req, m3_we, eobv3;
  logic [16:0]  m3_addr;
  logic [31:0]  eobc3;
  logic [63:0]  s1 = '0, s2 = '0, s3 = '0;

  tiny_soc_mem_arbiter #(.NumPorts(3), .MemLatency(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .we_i(we3),
    .addr_i(addr3), .be_i(be3), .wdata_i(wdata3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .err_o(err3), .mem_req_o(m3_req), .mem_we_o(m3_we),
    .mem_addr_o(m3_addr), .mem_wdata_o(m3_wdata), .mem_wmask_o(m3_mask),
    .mem_rdata_i(m3_rdata), .eob_valid_o(eobv3), .eob_code_o(eobc3)
  );

  // Three-stage SRAM read model; word w holds {C0DE0000, w}.
  always @(posedge clk) begin
    if (m3_req && !m3_we) s1 <= {32'hC0DE_0000, 15'd0, m3_addr};
    s2 <= s1;
    s3 <= s2;
  end
  assign m3_rdata = s3;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        x_mreq;
    logic [16:0] x_maddr;
    logic [63:0] x_mask;
    logic        x_err;
    logic [63:0] x_rdata;
    logic        x_eobv;
    logic [31:0] x_eobc;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 32'h8000_0008, 8'hFF, 64'h1122334455667788, 1'b1, 17'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h8000_0008, 8'hFF, 64'h0,                1'b1, 17'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1122334455667788, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 32'h8000_0008, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 17'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h8000_000C, 8'hFF, 64'h0,                1'b1, 17'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h11223344AAAAAAAA, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h8000_0010, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 17'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 32'h8000_0010, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 17'd2, 64'h0, 1'b0, 64'h0, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 32'h8000_0010, 8'hFF, 64'h0,                1'b1, 17'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0123456789ABCDEF, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h7FFF_FFF8, 8'hFF, 64'h0,                1'b0, 17'd0, 64'h0, 1'b1, 64'h0, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h8010_0000, 8'hFF, 64'h0,                1'b0, 17'd0, 64'h0, 1'b1, 64'h0, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 32'h800F_FFF8, 8'hFF, 64'hCAFEF00DDEADBEEF, 1'b1, 17'h1FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 32'h0};
    vt[10] = '{1'b0, 32'h800F_FFF8, 8'hFF, 64'h0,                1'b1, 17'h1FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hCAFEF00DDEADBEEF, 1'b0, 32'h0};
    vt[11] = '{1'b1, 32'h0000_0000, 8'hFF, 64'h0000_0000_0000_0001, 1'b0, 17'd0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h1};
    vt[12] = '{1'b1, 32'h0000_0000, 8'hFF, 64'h0000_0000_0000_0005, 1'b0, 17'd0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h1};
    vt[13] = '{1'b0, 32'h0000_0000, 8'hFF, 64'h0,                1'b0, 17'd0, 64'h0, 1'b1, 64'h0, 1'b1, 32'h1};
    vt[14] = '{1'b1, 32'h7FFF_FFF8, 8'hFF, 64'h5555_5555_5555_5555, 1'b0, 17'd0, 64'h0, 1'b1, 64'h0, 1'b1, 32'h1};

    // Reset state, with requests pending to show grants are held off.
    rst_n = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8000_0000; be1 = 8'hFF; wdata1 = '0;
    req3 = 3'b111; we3 = '0; be3 = '1; wdata3 = '0;
    addr3 = {32'h8000_0010, 32'h8000_0008, 32'h8000_0000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt1",    64'(gnt1),    64'd0);
    chk("rst.gnt3",    64'(gnt3),    64'd0);
    chk("rst.mreq1",   64'(m1_req),  64'd0);
    chk("rst.mreq3",   64'(m3_req),  64'd0);
    chk("rst.rvalid1", 64'(rvalid1), 64'd0);
    chk("rst.rvalid3", 64'(rvalid3), 64'd0);
    chk("rst.err1",    64'(err1),    64'd0);
    chk("rst.rdata1",  rdata1,       64'd0);
    chk("rst.eobv1",   64'(eobv1),   64'd0);
    chk("rst.eobc1",   64'(eobc1),   64'd0);
    req1 = 1'b0; req3 = 3'b000;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one transaction per vector on the single-port instance.
    for (int i = 0; i < NV; i++) begin
      req1 = 1'b1; we1 = vt[i].we; addr1 = vt[i].addr; be1 = vt[i].be; wdata1 = vt[i].wdata;
      #1;
      chk($sformatf("v%0d.gnt", i),  64'(gnt1),   64'd1);
      chk($sformatf("v%0d.mreq", i), 64'(m1_req), 64'(vt[i].x_mreq));
      if (vt[i].x_mreq) begin
        chk($sformatf("v%0d.maddr", i), 64'(m1_addr), 64'(vt[i].x_maddr));
        chk($sformatf("v%0d.mask", i),  m1_mask,      vt[i].x_mask);
        chk($sformatf("v%0d.mwe", i),   64'(m1_we),   64'(vt[i].we));
      end
      @(posedge clk); #1;
      req1 = 1'b0;
      #1;
      chk($sformatf("v%0d.rvalid", i), 64'(rvalid1), 64'd1);
      chk($sformatf("v%0d.err", i),    64'(err1),    64'(vt[i].x_err));
      chk($sformatf("v%0d.rdata", i),  rdata1,       vt[i].x_rdata);
      chk($sformatf("v%0d.eobv", i),   64'(eobv1),   64'(vt[i].x_eobv));
      chk($sformatf("v%0d.eobc", i),   64'(eobc1),   64'(vt[i].x_eobc));
      @(posedge clk); #1;
      chk($sformatf("v%0d.idle_rvalid", i), 64'(rvalid1), 64'd0);
    end

    // Three ports requesting continuously: rotation and latency-3 routing.
    for (int c = 0; c < 10; c++) begin
      req3 = (c < 6) ? 3'b111 : 3'b000;
      #1;
      chk($sformatf("rr%0d.gnt", c), 64'(gnt3),
          (c < 6) ? 64'(1 << (c % 3)) : 64'd0);
      if (c < 6) chk($sformatf("rr%0d.maddr", c), 64'(m3_addr), 64'(c % 3));
      chk($sformatf("rr%0d.rvalid", c), 64'(rvalid3),
          (c >= 3 && c < 9) ? 64'(1 << ((c - 3) % 3)) : 64'd0);
      if (c >= 3 && c < 9)
        chk($sformatf("rr%0d.rdata", c), rdata3, {32'hC0DE_0000, 32'((c - 3) % 3)});
      chk($sformatf("rr%0d.err", c), 64'(err3), 64'd0);
      @(posedge clk); #1;
    end

    // Two reads in flight (ports 0 then 1, leaving pointer at 2), then reset.
    req3 = 3'b001;
    #1;
    chk("fl.gnt0", 64'(gnt3), 64'd1);
    @(posedge clk); #1;
    req3 = 3'b010;
    #1;
    chk("fl.gnt1", 64'(gnt3), 64'd2);
    @(posedge clk); #1;
    req3 = 3'b111;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.gnt3",    64'(gnt3),    64'd0);
    chk("ar.mreq3",   64'(m3_req),  64'd0);
    chk("ar.rvalid3", 64'(rvalid3), 64'd0);
    chk("ar.err3",    64'(err3),    64'd0);
    chk("ar.rdata3",  rdata3,       64'd0);
    chk("ar.eobv1",   64'(eobv1),   64'd0);
    chk("ar.eobc1",   64'(eobc1),   64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    req3 = 3'b000;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("post%0d.rvalid3", c), 64'(rvalid3), 64'd0);
      @(posedge clk); #1;
    end
    req3 = 3'b111;
    #1;
    chk("post.gnt_restart", 64'(gnt3), 64'd1);
    @(posedge clk); #1;
    req3 = 3'b000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
